// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: default sizes, reset vector,
// 2-bit counter encodings and the BTB entry record.
package branch_predictor_pkg;

  localparam int GHR_WIDTH_DEF   = 5;
  localparam int BTB_INDEX_W_DEF = 6;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } counter_t;

  // Tag is stored as the PC shifted right by the index+offset bits, so the
  // record stays valid for any BTB depth; unused upper tag bits remain zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic        is_branch;
    logic        is_jump;
    logic [31:0] target;
  } btb_entry_t;

  function automatic logic [1:0] counter_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != CNT_ST) nxt = cnt + 2'd1;
    else if (!taken && cnt != CNT_SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational read on the fetch PC,
// synchronous write from resolved-instruction feedback.
module bp_btb
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        hit,
  output logic        hit_branch,
  output logic        hit_jump,
  output logic [31:0] hit_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic        wr_branch,
  input  logic        wr_jump,
  input  logic [31:0] wr_target
);

  localparam int ENTRIES = 2 ** INDEX_W;

  btb_entry_t       mem [ENTRIES];
  btb_entry_t       rd_entry;
  logic [INDEX_W-1:0] rd_idx;
  logic [INDEX_W-1:0] wr_idx;

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (INDEX_W + 2);
  endfunction

  assign rd_idx     = rd_pc[INDEX_W+1:2];
  assign wr_idx     = wr_pc[INDEX_W+1:2];
  assign rd_entry   = mem[rd_idx];
  assign hit        = rd_entry.valid && (rd_entry.tag == tag_of(rd_pc));
  assign hit_branch = rd_entry.is_branch;
  assign hit_jump   = rd_entry.is_jump;
  assign hit_target = rd_entry.target;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (wr_en) begin
      mem[wr_idx] <= '{valid: 1'b1, tag: tag_of(wr_pc), is_branch: wr_branch,
                       is_jump: wr_jump, target: wr_target};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Global-history branch predictor with BTB and a pipeline output register.
// Define BP_GSHARE_EN to hash the PC into the PHT index (gshare); otherwise GHR only.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int GHR_WIDTH   = GHR_WIDTH_DEF,
  parameter int BTB_INDEX_W = BTB_INDEX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall_current_stage,
  input  logic                 stall_next_stage,
  input  logic [31:0]          pc_in,
  input  logic                 is_branch_in,
  input  logic                 is_jump_in,
  input  logic                 is_taken_in,
  input  logic                 is_miss_in,
  input  logic [GHR_WIDTH-1:0] last_pht_index,
  input  logic [31:0]          inst_pc,
  input  logic [31:0]          target_in,
  output logic [31:0]          next_pc_out,
  output logic                 is_branch_taken_out,
  output logic [GHR_WIDTH-1:0] current_pht_index_out,
  output logic [31:0]          current_pc_out
);

  localparam int PHT_ENTRIES = 2 ** GHR_WIDTH;

  logic [GHR_WIDTH-1:0] ghr;
  logic [GHR_WIDTH-1:0] pht_index;
  logic [1:0]           pht [PHT_ENTRIES];

  logic        btb_hit;
  logic        btb_branch;
  logic        btb_jump;
  logic [31:0] btb_target;
  logic        pred_taken;

`ifdef BP_GSHARE_EN
  assign pht_index = ghr ^ pc_in[GHR_WIDTH+1:2];
`else
  assign pht_index = ghr;
`endif

  bp_btb #(.INDEX_W(BTB_INDEX_W)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc_in),
    .hit       (btb_hit),
    .hit_branch(btb_branch),
    .hit_jump  (btb_jump),
    .hit_target(btb_target),
    .wr_en     (is_branch_in | is_jump_in),
    .wr_pc     (inst_pc),
    .wr_branch (is_branch_in),
    .wr_jump   (is_jump_in),
    .wr_target (target_in)
  );

  assign pred_taken = btb_hit && (btb_jump || (btb_branch && pht[pht_index][1]));

  // A resolved mispredict always wins over the speculative lookup.
  always_comb begin
    next_pc_out = pc_in + 32'd4;
    if (is_miss_in && is_taken_in) next_pc_out = target_in;
    else if (is_miss_in) next_pc_out = inst_pc + 32'd8;
    else if (pred_taken) next_pc_out = btb_target;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CNT_WNT;
    end else if (is_branch_in) begin
      ghr                 <= {ghr[GHR_WIDTH-2:0], is_taken_in};
      pht[last_pht_index] <= counter_next(pht[last_pht_index], is_taken_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush || (stall_current_stage && !stall_next_stage)) begin
      is_branch_taken_out   <= 1'b0;
      current_pht_index_out <= '0;
      current_pc_out        <= '0;
    end else if (!stall_current_stage) begin
      is_branch_taken_out   <= pred_taken;
      current_pht_index_out <= pht_index;
      current_pc_out        <= pc_in;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, compared against a table-based behavioural model.
module tb_branch_predictor;

  localparam int GW = 5;
  localparam int BW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          stall_current_stage;
  logic          stall_next_stage;
  logic [31:0]   pc_in;
  logic          is_branch_in;
  logic          is_jump_in;
  logic          is_taken_in;
  logic          is_miss_in;
  logic [GW-1:0] last_pht_index;
  logic [31:0]   inst_pc;
  logic [31:0]   target_in;
  logic [31:0]   next_pc_out;
  logic          is_branch_taken_out;
  logic [GW-1:0] current_pht_index_out;
  logic [31:0]   current_pc_out;

  always #5 clk = ~clk;

  branch_predictor #(.GHR_WIDTH(GW), .BTB_INDEX_W(BW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .stall_current_stage  (stall_current_stage),
    .stall_next_stage     (stall_next_stage),
    .pc_in                (pc_in),
    .is_branch_in         (is_branch_in),
    .is_jump_in           (is_jump_in),
    .is_taken_in          (is_taken_in),
    .is_miss_in           (is_miss_in),
    .last_pht_index       (last_pht_index),
    .inst_pc              (inst_pc),
    .target_in            (target_in),
    .next_pc_out          (next_pc_out),
    .is_branch_taken_out  (is_branch_taken_out),
    .current_pht_index_out(current_pht_index_out),
    .current_pc_out       (current_pc_out)
  );

  // Behavioural model: plain tables indexed by integer arithmetic on PCs.
  int unsigned m_ghr;
  int unsigned m_pht [32];
  bit          m_bv [64];
  int unsigned m_btag [64];
  bit          m_bbr [64];
  bit          m_bj [64];
  int unsigned m_btgt [64];
  bit          m_taken_q;
  int unsigned m_idx_q;
  int unsigned m_pc_q;

  int vectors = 0;
  int miscompares = 0;

  function automatic int unsigned m_index(int unsigned pc);
`ifdef BP_GSHARE_EN
    return (m_ghr ^ (pc / 4)) % 32;
`else
    return m_ghr;
`endif
  endfunction

  function automatic bit m_predict(int unsigned pc);
    int unsigned e;
    bit hit;
    e = (pc / 4) % 64;
    hit = m_bv[e] && (m_btag[e] == pc / 256);
    return hit && (m_bj[e] || (m_bbr[e] && m_pht[m_index(pc)] >= 2));
  endfunction

  function automatic int unsigned m_next_pc();
    int unsigned pc;
    pc = pc_in;
    if (is_miss_in && is_taken_in) return target_in;
    if (is_miss_in) return inst_pc + 32'd8;
    if (m_predict(pc)) return m_btgt[(pc / 4) % 64];
    return pc + 32'd4;
  endfunction

  task automatic m_reset();
    m_ghr = 0;
    for (int i = 0; i < 32; i++) m_pht[i] = 1;
    for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
    m_taken_q = 1'b0;
    m_idx_q = 0;
    m_pc_q = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; stall_current_stage = 0; stall_next_stage = 0;
    is_branch_in = 0; is_jump_in = 0; is_taken_in = 0; is_miss_in = 0;
    last_pht_index = '0; inst_pc = '0; target_in = '0;
  endtask

  // One clock: check combinational next PC, advance model and DUT, check registers.
  task automatic step();
    bit          taken;
    int unsigned idx;
    int unsigned e;
    #1;
    check("next_pc", next_pc_out, m_next_pc());
    taken = m_predict(pc_in);
    idx = m_index(pc_in);
    @(posedge clk);
    if (!rst) begin
      m_reset();
    end else begin
      if (flush || (stall_current_stage && !stall_next_stage)) begin
        m_taken_q = 0; m_idx_q = 0; m_pc_q = 0;
      end else if (!stall_current_stage) begin
        m_taken_q = taken; m_idx_q = idx; m_pc_q = pc_in;
      end
      if (is_branch_in || is_jump_in) begin
        e = (inst_pc / 4) % 64;
        m_bv[e] = 1; m_btag[e] = inst_pc / 256;
        m_bbr[e] = is_branch_in; m_bj[e] = is_jump_in; m_btgt[e] = target_in;
      end
      if (is_branch_in) begin
        if (is_taken_in && m_pht[last_pht_index] < 3) m_pht[last_pht_index]++;
        if (!is_taken_in && m_pht[last_pht_index] > 0) m_pht[last_pht_index]--;
        m_ghr = (m_ghr * 2 + (is_taken_in ? 1 : 0)) % 32;
      end
    end
    #1;
    check("taken_q", {31'd0, is_branch_taken_out}, {31'd0, m_taken_q});
    check("pht_idx_q", {27'd0, current_pht_index_out}, m_idx_q);
    check("pc_q", current_pc_out, m_pc_q);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    case ($urandom_range(0, 2))
      0: base = 32'hbfc00000;
      1: base = 32'hbfd00000;
      default: base = 32'hffffff00;
    endcase
    return base + 32'($urandom_range(0, 63) * 4);
  endfunction

  localparam logic [31:0] RV = 32'hbfc00000;
  localparam logic [31:0] P  = 32'hbfc00080;
  localparam logic [31:0] T  = 32'hbfc00200;

  initial begin
    int r;
    idle();
    rst = 0;
    pc_in = RV;
    @(posedge clk);
    m_reset();
    #1;
    check("rst_taken", {31'd0, is_branch_taken_out}, 32'd0);
    check("rst_pc", current_pc_out, 32'd0);

    // Reset held: next PC still combinational.
    #1;
    check("rst_next_pc", next_pc_out, 32'hbfc00004);
    step();
    rst = 1;
    step();
    check("first_pc", current_pc_out, RV);
    check("first_taken", {31'd0, is_branch_taken_out}, 32'd0);

    // Taken mispredicted branch redirects immediately and shifts a 1 into GHR.
    is_branch_in = 1; is_taken_in = 1; is_miss_in = 1;
    inst_pc = 32'hbfc00010; target_in = 32'hbfc00124; last_pht_index = '0;
    #1;
    check("miss_taken_redirect", next_pc_out, 32'hbfc00124);
    step();
    idle();
    step();
    check("ghr_lsb", {31'd0, current_pht_index_out[0]}, 32'd1);

    // Jump learned into the BTB, then predicted on fetch.
    is_jump_in = 1; is_taken_in = 1; is_miss_in = 1;
    inst_pc = 32'hbfc00020; target_in = 32'hbfc00300;
    step();
    idle();
    pc_in = 32'hbfc00020;
    #1;
    check("jump_pred_next", next_pc_out, 32'hbfc00300);
    step();
    check("jump_pred_taken", {31'd0, is_branch_taken_out}, 32'd1);

    // Not-taken miss goes past the delay slot; fetch PC wraps.
    is_miss_in = 1; is_taken_in = 0; inst_pc = 32'hbfc00040;
    #1;
    check("miss_nt_next", next_pc_out, 32'hbfc00048);
    step();
    idle();
    pc_in = 32'hfffffffc;
    #1;
    check("wrap_next", next_pc_out, 32'h00000000);
    step();

    // Train PHT[31] up twice, steer GHR to all ones, then predict P.
    pc_in = RV;
    is_branch_in = 1; is_taken_in = 1; inst_pc = P; target_in = T;
    last_pht_index = 5'd31;
    repeat (2) step();
    last_pht_index = 5'd5;
    repeat (5) step();
    idle();
    pc_in = P;
`ifndef BP_GSHARE_EN
    #1;
    check("trained_taken", next_pc_out, T);
`endif
    step();
    // Four not-taken updates saturate PHT[31] at 0.
    pc_in = RV;
    is_branch_in = 1; is_taken_in = 0; inst_pc = P; target_in = T;
    last_pht_index = 5'd31;
    repeat (4) step();
    is_taken_in = 1; last_pht_index = 5'd5;
    repeat (5) step();
    idle();
    pc_in = P;
`ifndef BP_GSHARE_EN
    #1;
    check("trained_not_taken", next_pc_out, P + 32'd4);
`endif
    step();

    // Stall hold, bubble and flush.
    pc_in = 32'hbfc00400;
    step();
    stall_current_stage = 1; stall_next_stage = 1; pc_in = 32'hbfc00500;
    step();
    check("stall_hold", current_pc_out, 32'hbfc00400);
    stall_next_stage = 0;
    step();
    check("bubble", current_pc_out, 32'd0);
    idle();
    pc_in = 32'hbfc00600;
    step();
    flush = 1; stall_current_stage = 1; stall_next_stage = 1;
    step();
    check("flush", current_pc_out, 32'd0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      pc_in = rand_pc();
      r = $urandom_range(0, 9);
      is_branch_in = (r < 4);
      is_jump_in = (r == 4 || r == 5);
      is_taken_in = $urandom_range(0, 1) != 0;
      is_miss_in = ($urandom_range(0, 4) == 0);
      inst_pc = rand_pc();
      target_in = $urandom;
      last_pht_index = GW'($urandom_range(0, 31));
      flush = ($urandom_range(0, 9) == 0);
      stall_current_stage = ($urandom_range(0, 4) == 0);
      stall_next_stage = $urandom_range(0, 1) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter GHR_WIDTH, default 5, global history length and PHT index width.
REQ-002 Parameter BTB_INDEX_W, default 6, BTB has 2**BTB_INDEX_W direct-mapped entries.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 flush, stall_current_stage, stall_next_stage  in  1 each  pipeline control for the output register.
REQ-006 pc_in  in  32  fetch PC of the current cycle.
REQ-007 is_branch_in, is_jump_in, is_taken_in, is_miss_in  in  1 each  resolved-instruction feedback.
REQ-008 last_pht_index  in  GHR_WIDTH  PHT index carried with the resolved branch.
REQ-009 inst_pc, target_in  in  32 each  resolved instruction PC and actual target.
REQ-010 next_pc_out  out  32  combinational next fetch PC.
REQ-011 is_branch_taken_out, current_pht_index_out (GHR_WIDTH), current_pc_out (32)  out  registered prediction record for the next stage.

Function
REQ-012 PHT index = GHR xor pc_in[GHR_WIDTH+1:2]; PHT holds 2**GHR_WIDTH 2-bit saturating counters; predict taken when counter[1]=1.
REQ-013 BTB index = pc_in[BTB_INDEX_W+1:2]; each entry holds valid, tag pc[31:BTB_INDEX_W+2], is_branch, is_jump, target[31:0]; a hit requires valid and tag match.
REQ-014 Prediction (combinational): hit and is_jump -> taken; hit and is_branch and PHT taken -> taken; otherwise not taken.
REQ-015 next_pc_out priority: is_miss_in=1 and is_taken_in=1 -> target_in; is_miss_in=1 and is_taken_in=0 -> inst_pc+8 (delay slot); predicted taken -> BTB target; else pc_in+4.
REQ-016 Feedback update, same edge: is_branch_in or is_jump_in writes BTB entry for inst_pc (valid=1, tag, flags, target_in).
REQ-017 is_branch_in=1: GHR <= {GHR[GHR_WIDTH-2:0], is_taken_in}; PHT[last_pht_index] increments (taken) or decrements (not taken), saturating at 3 and 0.
REQ-018 Jumps do not touch GHR or PHT; with no feedback asserted, no state changes.
REQ-019 Lookup reads pre-update state; same-cycle update to the looked-up entry is not bypassed.
REQ-020 Output register: flush=1 -> all outputs 0; else stall_current_stage=1 and stall_next_stage=0 -> all 0 (bubble); else stall_current_stage=1 -> hold; else load {prediction, PHT index, pc_in}.
REQ-021 Arithmetic modulo 2**32; pc+4 / inst_pc+8 wrap silently.

Reset
REQ-022 While rst=0 at a rising edge: GHR=0, all PHT counters=2'b01 (weakly not taken), all BTB valid=0, registered outputs all 0.
REQ-023 next_pc_out stays combinational during reset (pc_in+4 since BTB invalid, unless is_miss_in).
REQ-024 Reset overrides flush, stall and feedback updates in the same cycle.

Configuration
REQ-025 Macro BP_GSHARE_EN: defined -> PHT index per REQ-012; undefined -> PHT index = GHR only (pure global history); all else unchanged.

Structure
REQ-026 Shared package holds GHR_WIDTH default, reset vector 32'hbfc00000, counter encodings and BTB entry struct type.
REQ-027 BTB is one sub-module bp_btb (read port on pc_in, write port on inst_pc); PHT, GHR and output register live in the top.

Verification
REQ-028 Reset then pc_in=32'hbfc00000, no feedback -> next_pc_out=32'hbfc00004, registered outputs 0 during reset, then current_pc_out=32'hbfc00000, is_branch_taken_out=0.
REQ-029 Feedback is_branch_in=1, is_taken_in=1, is_miss_in=1, inst_pc=32'hbfc00010, target_in=32'hbfc00124 -> next_pc_out=32'hbfc00124 same cycle; GHR LSB=1 next cycle.
REQ-030 Jump feedback inst_pc=32'hbfc00020, target_in=32'hbfc00300, is_miss_in=1; later pc_in=32'hbfc00020 -> next_pc_out=32'hbfc00300, is_branch_taken_out=1 next edge.
REQ-031 Same PHT index trained taken twice from reset (01->10->11) with BTB branch entry -> predicted taken to target; three not-taken updates -> 00, saturates, predicts pc_in+4.
REQ-032 stall_current_stage=1, stall_next_stage=1 holds outputs; stall_next_stage=0 gives zeros; flush=1 zeros regardless of stalls.
REQ-033 is_miss_in=1, is_taken_in=0, inst_pc=32'hbfc00040 -> next_pc_out=32'hbfc00048; pc_in=32'hfffffffc, no hit -> 32'h00000000.
